// File: rtl/uart_transceiver_if.sv
// Byte-level and serial-pin signals of the UART; slave is the UART, master is the controller/bench side.
// No flow control beyond o_tx_available: requests made while it is low are lost.
interface uart_transceiver_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_WIDTH = 1
);
  localparam int PW = (PARITY_WIDTH > 0) ? PARITY_WIDTH : 1;

  logic                  i_rx_data;
  logic                  i_tx_signal;
  logic [DATA_WIDTH-1:0] i_tx_result;
  logic [PW-1:0]         i_parity;
  logic                  o_rx_done;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic [PW-1:0]         o_parity;
  logic                  o_tx_data;
  logic                  o_tx_done;
  logic                  o_tx_available;

  modport master (
    output i_rx_data, i_tx_signal, i_tx_result, i_parity,
    input  o_rx_done, o_rx_data, o_parity, o_tx_data, o_tx_done, o_tx_available
  );

  modport slave (
    input  i_rx_data, i_tx_signal, i_tx_result, i_parity,
    output o_rx_done, o_rx_data, o_parity, o_tx_data, o_tx_done, o_tx_available
  );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex UART, 16x oversampled; a TX frame takes (1+DATA+PARITY+STOP)*16*TICK_DIV clocks.
// TX accepts one request when o_tx_available is high; RX has no backpressure (o_rx_done is a pulse).
module uart_transceiver #(
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_WIDTH   = 1,
  parameter int PARITY_WIDTH = 1,
  parameter int TICK_DIV     = 55
) (
  input  logic              i_clock,
  input  logic              i_reset,
  uart_transceiver_if.slave bus
);
  localparam int PW = (PARITY_WIDTH > 0) ? PARITY_WIDTH : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(DATA_WIDTH + STOP_WIDTH) + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) tick_cnt_q <= '0;
    else          tick_cnt_q <= tick_cnt_d;
  end

  state_t                tx_state_q;
  logic [3:0]            tx_tick_q;
  logic [BW-1:0]         tx_bit_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic [PW-1:0]         tx_parity_q;
  logic                  tx_line_q, tx_done_q, tx_avail_q;
  logic                  tx_bit_end;

  assign tx_bit_end = tick && (tx_tick_q == 4'd15);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tx_state_q  <= ST_IDLE;
      tx_tick_q   <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_parity_q <= '0;
      tx_line_q   <= 1'b1;
      tx_done_q   <= 1'b0;
      tx_avail_q  <= 1'b1;
    end else begin
      tx_done_q <= 1'b0;
      if (tx_state_q != ST_IDLE && tick) tx_tick_q <= tx_tick_q + 4'd1;
      case (tx_state_q)
        ST_IDLE: if (bus.i_tx_signal) begin
          tx_shift_q  <= bus.i_tx_result;
          tx_parity_q <= {PW{^bus.i_tx_result}};
          tx_line_q   <= 1'b0;
          tx_avail_q  <= 1'b0;
          tx_tick_q   <= '0;
          tx_state_q  <= ST_START;
        end
        ST_START: if (tx_bit_end) begin
          tx_line_q  <= tx_shift_q[0];
          tx_bit_q   <= '0;
          tx_state_q <= ST_DATA;
        end
        ST_DATA: if (tx_bit_end) begin
          if (tx_bit_q == BW'(DATA_WIDTH - 1)) begin
            tx_bit_q <= '0;
            if (PARITY_WIDTH > 0) begin
              tx_line_q  <= tx_parity_q[0];
              tx_state_q <= ST_PARITY;
            end else begin
              tx_line_q  <= 1'b1;
              tx_state_q <= ST_STOP;
            end
          end else begin
            tx_bit_q   <= tx_bit_q + BW'(1);
            tx_shift_q <= tx_shift_q >> 1;
            tx_line_q  <= tx_shift_q[1];
          end
        end
        ST_PARITY: if (tx_bit_end) begin
          tx_line_q  <= 1'b1;
          tx_state_q <= ST_STOP;
        end
        ST_STOP: if (tx_bit_end) begin
          if (tx_bit_q == BW'(STOP_WIDTH - 1)) begin
            tx_done_q  <= 1'b1;
            tx_avail_q <= 1'b1;
            tx_state_q <= ST_IDLE;
          end else begin
            tx_bit_q <= tx_bit_q + BW'(1);
          end
        end
        default: tx_state_q <= ST_IDLE;
      endcase
    end
  end

  logic [1:0]            rx_sync_q;
  state_t                rx_state_q;
  logic [3:0]            rx_tick_q;
  logic [BW-1:0]         rx_bit_q;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_data_q;
  logic                  rx_par_q, rx_done_q, rx_hold_q;
  logic                  rx_in, rx_bit_end;

  assign rx_in      = rx_sync_q[1];
  assign rx_bit_end = tick && (rx_tick_q == 4'd15);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= ST_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_par_q   <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_hold_q  <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], bus.i_rx_data};
      rx_done_q <= 1'b0;
      if (rx_state_q != ST_IDLE && tick) rx_tick_q <= rx_tick_q + 4'd1;
      case (rx_state_q)
        ST_IDLE: if (!rx_in) begin
          rx_tick_q  <= '0;
          rx_state_q <= ST_START;
        end
        ST_START: if (tick && rx_tick_q == 4'd7) begin
          if (rx_in) begin
            rx_state_q <= ST_IDLE;
          end else begin
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= ST_DATA;
          end
        end
        ST_DATA: if (rx_bit_end) begin
          rx_shift_q <= {rx_in, rx_shift_q[DATA_WIDTH-1:1]};
          if (rx_bit_q == BW'(DATA_WIDTH - 1)) begin
            rx_state_q <= (PARITY_WIDTH > 0) ? ST_PARITY : ST_STOP;
          end else begin
            rx_bit_q <= rx_bit_q + BW'(1);
          end
        end
        ST_PARITY: if (rx_bit_end) begin
          rx_par_q   <= rx_in;
          rx_state_q <= ST_STOP;
        end
        ST_STOP: if (rx_hold_q) begin
          // Framing error: stay out of IDLE until the line returns high.
          if (rx_in) begin
            rx_hold_q  <= 1'b0;
            rx_state_q <= ST_IDLE;
          end
        end else if (rx_bit_end) begin
          if (!rx_in) begin
            rx_hold_q <= 1'b1;
          end else begin
            if (PARITY_WIDTH == 0 || rx_par_q == ^rx_shift_q) begin
              rx_data_q <= rx_shift_q;
              rx_done_q <= 1'b1;
            end
            rx_state_q <= ST_IDLE;
          end
        end
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

  logic unused_parity_in;
  assign unused_parity_in = ^bus.i_parity;

  assign bus.o_tx_data      = tx_line_q;
  assign bus.o_tx_done      = tx_done_q;
  assign bus.o_tx_available = tx_avail_q;
  assign bus.o_parity       = tx_parity_q;
  assign bus.o_rx_done      = rx_done_q;
  assign bus.o_rx_data      = rx_data_q;
endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: reset, loopback, busy-drop, framing/parity errors, glitch, mid-frame reset.
module tb_uart_transceiver;
  localparam int TD        = 8;
  localparam int BIT_CLK   = 16 * TD;
  localparam int FRAME_CLK = 11 * BIT_CLK;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_transceiver_if #(.DATA_WIDTH(8), .PARITY_WIDTH(1)) bus();

  logic loop_en = 1'b0;
  logic rx_drv  = 1'b1;
  assign bus.i_rx_data = loop_en ? bus.o_tx_data : rx_drv;

  uart_transceiver #(
    .DATA_WIDTH(8), .STOP_WIDTH(1), .PARITY_WIDTH(1), .TICK_DIV(TD)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus.slave)
  );

  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         tx_done_cyc = 0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (bus.o_rx_done === 1'b1) begin
      rx_cnt <= rx_cnt + 1;
      rx_log.push_back(bus.o_rx_data);
    end
    if (bus.o_tx_done === 1'b1) begin
      tx_cnt      <= tx_cnt + 1;
      tx_done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int req_cyc);
    int n = 0;
    while (bus.o_tx_available !== 1'b1 && n < 2 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    check("tx_avail_before_req", bus.o_tx_available, 1);
    bus.i_tx_result = b;
    bus.i_tx_signal = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    bus.i_tx_signal = 1'b0;
    check("tx_avail_drop", bus.o_tx_available, 0);
  endtask

  task automatic wait_tx(input int target);
    int n = 0;
    while (tx_cnt < target && n < 3 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    check("tx_done_reached", tx_cnt >= target, 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    rx_drv = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx_drv = par;
    repeat (BIT_CLK) @(negedge clk);
    rx_drv = stp;
    repeat (BIT_CLK) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
  endtask

  initial begin
    int         req, n0, r0, lat;
    logic [10:0] line;
    logic [7:0]  exp_b;

    bus.i_tx_signal = 1'b0;
    bus.i_tx_result = '0;
    bus.i_parity    = '0;
    repeat (5) @(negedge clk);

    check("rst_tx_data",  bus.o_tx_data, 1);
    check("rst_tx_avail", bus.o_tx_available, 1);
    check("rst_tx_done",  bus.o_tx_done, 0);
    check("rst_rx_done",  bus.o_rx_done, 0);
    check("rst_rx_data",  bus.o_rx_data, 8'h00);
    check("rst_parity",   bus.o_parity, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Loopback of 0x2A with the line waveform captured mid-bit.
    loop_en = 1'b1;
    n0 = tx_cnt;
    r0 = rx_cnt;
    send_byte(8'h2A, req);
    repeat (BIT_CLK / 2 - 1) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      line[k] = bus.o_tx_data;
      repeat (BIT_CLK) @(negedge clk);
    end
    wait_tx(n0 + 1);
    repeat (5) @(negedge clk);
    check("lb_line_2a", line, 11'b110_0101_0100);
    check("lb_parity",  bus.o_parity, 1);
    check("lb_tx_done_once", tx_cnt - n0, 1);
    check("lb_rx_done_once", rx_cnt - r0, 1);
    check("lb_rx_data", bus.o_rx_data, 8'h2A);
    lat = tx_done_cyc - req;
    check("lb_latency_window", (lat >= FRAME_CLK - TD) && (lat <= FRAME_CLK + TD), 1);
    check("lb_avail_back", bus.o_tx_available, 1);

    // Bytes of 0x00000000 then 0xFFFFFFFF, with one request dropped while busy.
    n0 = tx_cnt;
    r0 = rx_cnt;
    for (int i = 0; i < 8; i++) begin
      send_byte((i < 4) ? 8'h00 : 8'hFF, req);
      if (i == 2) begin
        repeat (300) @(negedge clk);
        bus.i_tx_result = 8'h77;
        bus.i_tx_signal = 1'b1;
        @(negedge clk);
        bus.i_tx_signal = 1'b0;
        check("busy_avail_low", bus.o_tx_available, 0);
      end
    end
    wait_tx(n0 + 8);
    repeat (FRAME_CLK + 200) @(negedge clk);
    check("words_tx_count", tx_cnt - n0, 8);
    check("words_rx_count", rx_cnt - r0, 8);
    for (int k = 0; k < 8; k++) begin
      exp_b = (k < 4) ? 8'h00 : 8'hFF;
      check("words_rx_byte", rx_log[r0 + k], exp_b);
    end
    check("words_parity_ff", bus.o_parity, 0);

    // Framing error, parity error, then a good 0x55.
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    r0 = rx_cnt;
    send_frame(8'h0F, 1'b0, 1'b0);
    check("ferr_no_pulse", rx_cnt - r0, 0);
    check("ferr_data_held", bus.o_rx_data, 8'hFF);
    send_frame(8'h33, 1'b1, 1'b1);
    check("perr_no_pulse", rx_cnt - r0, 0);
    check("perr_data_held", bus.o_rx_data, 8'hFF);
    send_frame(8'h55, 1'b0, 1'b1);
    check("good55_one_pulse", rx_cnt - r0, 1);
    check("good55_data", bus.o_rx_data, 8'h55);

    // Short low glitch (~200 clocks at the default baud) must not start a frame.
    r0 = rx_cnt;
    rx_drv = 1'b0;
    repeat (200 * TD / 55) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clk);
    check("glitch_no_pulse", rx_cnt - r0, 0);
    check("glitch_data_held", bus.o_rx_data, 8'h55);
    send_frame(8'hC3, 1'b0, 1'b1);
    check("after_glitch_pulse", rx_cnt - r0, 1);
    check("after_glitch_data", bus.o_rx_data, 8'hC3);

    // Reset in the middle of a TX frame.
    n0 = tx_cnt;
    send_byte(8'hA5, req);
    repeat (300) @(negedge clk);
    check("midrst_busy", bus.o_tx_available, 0);
    check("midrst_line_d1", bus.o_tx_data, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_line_high", bus.o_tx_data, 1);
    check("midrst_avail", bus.o_tx_available, 1);
    check("midrst_rx_data", bus.o_rx_data, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME_CLK) @(negedge clk);
    check("midrst_no_done", tx_cnt - n0, 0);
    check("midrst_idle_line", bus.o_tx_data, 1);

    loop_en = 1'b1;
    n0 = tx_cnt;
    r0 = rx_cnt;
    send_byte(8'h3C, req);
    wait_tx(n0 + 1);
    repeat (10) @(negedge clk);
    check("post_rst_rx_pulse", rx_cnt - r0, 1);
    check("post_rst_rx_data", bus.o_rx_data, 8'h3C);
    check("post_rst_parity", bus.o_parity, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
